// File: rtl/rms_mean_square.sv
// rms_mean_square: front-end of the RMS path. Squares signed samples taken on a
// valid/ready stream, averages them over a 2^LOG2_N window, and hands the mean
// square to the square-root stage using that stage's start/busy handshake.
// Optional feature: define RMS_PEAK_EN to add the per-window peak magnitude output.
module rms_mean_square #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LOG2_N = 4,
  parameter int unsigned OUT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              sq_start,
  output logic [OUT_W-1:0]  sq_rad,
  input  logic              sq_busy,
`ifdef RMS_PEAK_EN
  output logic [DATA_W-1:0] peak,
`endif
  output logic              win_done
);

  localparam int unsigned SqW  = 2 * DATA_W;
  localparam int unsigned AccW = SqW + LOG2_N;
  localparam logic [LOG2_N-1:0] CntLast = '1;

  typedef enum logic [1:0] {StIdle, StIssue, StGuard, StWait} state_e;

  state_e             state_q, state_d;
  logic [LOG2_N-1:0]  cnt_q, cnt_d;
  logic [AccW-1:0]    acc_q, acc_d;
  logic               pending_q, pending_d;
  logic [OUT_W-1:0]   ms_q, ms_d;
  logic [OUT_W-1:0]   rad_q, rad_d;
  logic               win_done_q;

  logic signed [SqW-1:0] s_ext;
  logic signed [SqW-1:0] sq_s;
  logic [SqW-1:0]        sq;
  logic [AccW-1:0]       acc_sum;
  logic [SqW-1:0]        mean;
  logic [OUT_W-1:0]      mean_sat;
  logic                  accept;
  logic                  last;
  logic                  win_end;
  logic                  issue_now;

  // Square in signed arithmetic; the result is always non-negative.
  assign s_ext   = SqW'($signed(s_data));
  assign sq_s    = s_ext * s_ext;
  assign sq      = $unsigned(sq_s);
  assign acc_sum = acc_q + AccW'(sq);
  assign mean    = acc_sum[AccW-1:LOG2_N];

  assign issue_now = (state_q == StIssue);
  assign last      = (cnt_q == CntLast);
  // Only the closing sample of a window can stall, and only while the previous
  // result still waits for its ISSUE cycle.
  assign s_ready   = !(pending_q && last && !issue_now);
  assign accept    = s_valid && s_ready;
  assign win_end   = accept && last;

  assign sq_start = issue_now;
  assign sq_rad   = rad_q;
  assign win_done = win_done_q;

  // Saturate the mean square into the radicand width.
  always_comb begin
    mean_sat = OUT_W'(mean);
    if (SqW > OUT_W) begin
      if ((mean >> OUT_W) != '0) mean_sat = '1;
    end
  end

  // Accumulator, window counter, captured result and handoff flag.
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ms_d      = ms_q;
    pending_d = pending_q;
    rad_d     = rad_q;
    if (issue_now) begin
      rad_d     = ms_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      if (last) begin
        cnt_d     = '0;
        acc_d     = '0;
        ms_d      = mean_sat;
        // A window closing during ISSUE re-arms pending for the new result.
        pending_d = 1'b1;
      end else begin
        cnt_d = cnt_q + LOG2_N'(1);
        acc_d = acc_sum;
      end
    end
  end

  // Handoff FSM next state: GUARD covers the cycle before the stage raises busy.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pending_q && !sq_busy) state_d = StIssue;
      StIssue: state_d = StGuard;
      StGuard: state_d = StWait;
      StWait:  if (!sq_busy) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_q      <= '0;
      pending_q  <= 1'b0;
      ms_q       <= '0;
      rad_q      <= '0;
      win_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      pending_q  <= pending_d;
      ms_q       <= ms_d;
      rad_q      <= rad_d;
      win_done_q <= win_end;
    end
  end

`ifdef RMS_PEAK_EN
  localparam logic [DATA_W-1:0] MinNeg = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] mag;
  logic [DATA_W-1:0] peak_new;
  logic [DATA_W-1:0] peak_run_q, peak_run_d;
  logic [DATA_W-1:0] peak_q, peak_d;

  // Magnitude of the sample; the most negative code clamps to the largest positive.
  always_comb begin
    if (s_data == MinNeg) begin
      mag = ~MinNeg;
    end else if (s_data[DATA_W-1]) begin
      mag = -s_data;
    end else begin
      mag = s_data;
    end
  end

  assign peak_new = (mag > peak_run_q) ? mag : peak_run_q;
  assign peak     = peak_q;

  // Running maximum over the open window; published together with the mean square.
  always_comb begin
    peak_run_d = peak_run_q;
    peak_d     = peak_q;
    if (accept) begin
      if (last) begin
        peak_d     = peak_new;
        peak_run_d = '0;
      end else begin
        peak_run_d = peak_new;
      end
    end
  end

  // Peak registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_run_q <= '0;
      peak_q     <= '0;
    end else begin
      peak_run_q <= peak_run_d;
      peak_q     <= peak_d;
    end
  end
`endif

endmodule

// File: tb/tb_rms_mean_square.sv
// tb_rms_mean_square: randomized and directed bench for rms_mean_square with a
// window-level reference model and a behavioural square-root stage busy model.
module tb_rms_mean_square;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned LOG2_N = 4;
  localparam int unsigned OUT_W  = 16;
  localparam int          N      = 1 << LOG2_N;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              sq_start;
  logic [OUT_W-1:0]  sq_rad;
  logic              sq_busy = 1'b0;
  logic              win_done;
`ifdef RMS_PEAK_EN
  logic [DATA_W-1:0] peak;
`endif

  int checks = 0;
  int errors = 0;

  int cycle = 0;
  int busy_mode = 0;  // 0: idle stage, 1: forced busy countdown, 2: stage model
  int busy_cnt = 0;
  int starts = 0;
  int win_count = 0;
  int start_busy_viol = 0;
  int first_start_cycle = -1;
  int last_accept_cycle = -1;
  int accepted = 0;
  int stall_cycles = 0;
  bit start_prev = 1'b0;

  int rad_seen[$];
  int peak_seen[$];
  int exp_rad[$];
  int exp_peak[$];
  int win_samples[$];

  rms_mean_square #(
    .DATA_W(DATA_W),
    .LOG2_N(LOG2_N),
    .OUT_W (OUT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .sq_start(sq_start),
    .sq_rad  (sq_rad),
    .sq_busy (sq_busy),
`ifdef RMS_PEAK_EN
    .peak    (peak),
`endif
    .win_done(win_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // Window-level reference: mean of squares over N samples, plus peak magnitude.
  function automatic void model_accept(input int v);
    longint sum;
    longint ms;
    int     pk;
    int     m;
    win_samples.push_back(v);
    if (win_samples.size() == N) begin
      sum = 0;
      pk  = 0;
      foreach (win_samples[i]) begin
        sum += longint'(win_samples[i]) * longint'(win_samples[i]);
        m = (win_samples[i] < 0) ? -win_samples[i] : win_samples[i];
        if (m > (1 << (DATA_W - 1)) - 1) m = (1 << (DATA_W - 1)) - 1;
        if (m > pk) pk = m;
      end
      ms = sum / N;
      if (ms > (longint'(1) << OUT_W) - 1) ms = (longint'(1) << OUT_W) - 1;
      exp_rad.push_back(int'(ms));
      exp_peak.push_back(pk);
      win_samples.delete();
    end
  endfunction

  task automatic clear_log();
    rad_seen.delete();
    peak_seen.delete();
    exp_rad.delete();
    exp_peak.delete();
    win_samples.delete();
    starts = 0;
    win_count = 0;
    start_busy_viol = 0;
    first_start_cycle = -1;
    last_accept_cycle = -1;
    accepted = 0;
    stall_cycles = 0;
    start_prev = 1'b0;
  endtask

  // Observe the current cycle, advance one clock, then update the busy model.
  task automatic tick(output bit acc);
    int sv;
    bit start_now;
    acc = s_valid && s_ready;
    if (s_valid && !s_ready) stall_cycles++;
    if (sq_start) begin
      starts++;
      if (sq_busy) start_busy_viol++;
      if (first_start_cycle < 0) first_start_cycle = cycle;
    end
    if (start_prev) rad_seen.push_back(int'(sq_rad));
    if (win_done) begin
      win_count++;
`ifdef RMS_PEAK_EN
      peak_seen.push_back(int'(peak));
`endif
    end
    if (acc) begin
      accepted++;
      last_accept_cycle = cycle;
      sv = int'($signed(s_data));
      model_accept(sv);
    end
    start_now = sq_start;
    @(posedge clk);
    #1;
    cycle++;
    start_prev = start_now;
    case (busy_mode)
      1: begin
        if (busy_cnt > 0) busy_cnt--;
        sq_busy = (busy_cnt > 0);
      end
      2: begin
        if (start_now) busy_cnt = 5;
        else if (busy_cnt > 0) busy_cnt--;
        sq_busy = (busy_cnt > 0);
      end
      default: sq_busy = 1'b0;
    endcase
  endtask

  task automatic send(input int v);
    bit a;
    s_valid = 1'b1;
    s_data  = v[DATA_W-1:0];
    for (int k = 0; k < 200; k++) begin
      tick(a);
      if (a) break;
    end
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int k = 0; k < n; k++) tick(a);
  endtask

  task automatic drain(input int n);
    bit a;
    for (int k = 0; k < 400 && rad_seen.size() < n; k++) tick(a);
    for (int k = 0; k < 12; k++) tick(a);
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    #1;
    checks++;
    if (sq_start !== 1'b0) begin
      errors++; $display("FAIL reset_sq_start: got %b expected 0", sq_start);
    end
    checks++;
    if (sq_rad !== '0) begin
      errors++; $display("FAIL reset_sq_rad: got %0d expected 0", sq_rad);
    end
    checks++;
    if (win_done !== 1'b0) begin
      errors++; $display("FAIL reset_win_done: got %b expected 0", win_done);
    end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL reset_s_ready: got %b expected 1", s_ready);
    end
`ifdef RMS_PEAK_EN
    checks++;
    if (peak !== '0) begin
      errors++; $display("FAIL reset_peak: got %0d expected 0", peak);
    end
`endif
    idle(3);
    rst_n = 1'b1;
    clear_log();
    idle(2);
  endtask

  task automatic test_const_windows();
    int pat_a[3] = '{3, -128, 4};
    int pat_b[3] = '{3, -128, -4};
    int exp_r[3] = '{9, 16384, 16};
    int got;
    busy_mode = 0;
    for (int p = 0; p < 3; p++) begin
      clear_log();
      for (int i = 0; i < N; i++) send((i % 2 == 0) ? pat_a[p] : pat_b[p]);
      drain(1);
      checks++;
      if (accepted != N) begin
        errors++; $display("FAIL const%0d_accepted: got %0d expected %0d", p, accepted, N);
      end
      checks++;
      if (win_count != 1) begin
        errors++; $display("FAIL const%0d_win_done: got %0d pulses expected 1", p, win_count);
      end
      checks++;
      if (starts != 1) begin
        errors++; $display("FAIL const%0d_starts: got %0d expected 1", p, starts);
      end
      checks++;
      if (first_start_cycle - last_accept_cycle != 2) begin
        errors++;
        $display("FAIL const%0d_latency: got %0d cycles expected 2", p,
                 first_start_cycle - last_accept_cycle);
      end
      got = (rad_seen.size() > 0) ? rad_seen[0] : -1;
      checks++;
      if (got != exp_r[p]) begin
        errors++; $display("FAIL const%0d_sq_rad: got %0d expected %0d", p, got, exp_r[p]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int got;
    clear_log();
    busy_mode = 1;
    busy_cnt  = 60;
    sq_busy   = 1'b1;
    for (int i = 0; i < 2 * N; i++) send(2);
    drain(2);
    busy_mode = 0;
    checks++;
    if (accepted != 2 * N) begin
      errors++; $display("FAIL b2b_accepted: got %0d expected %0d", accepted, 2 * N);
    end
    checks++;
    if (start_busy_viol != 0) begin
      errors++; $display("FAIL b2b_start_busy: got %0d starts under busy expected 0", start_busy_viol);
    end
    checks++;
    if (stall_cycles == 0) begin
      errors++; $display("FAIL b2b_stall: got %0d stall cycles expected >0", stall_cycles);
    end
    checks++;
    if (last_accept_cycle != first_start_cycle) begin
      errors++;
      $display("FAIL b2b_release: got accept cycle %0d expected first issue cycle %0d",
               last_accept_cycle, first_start_cycle);
    end
    checks++;
    if (starts != 2) begin
      errors++; $display("FAIL b2b_starts: got %0d expected 2", starts);
    end
    for (int i = 0; i < 2; i++) begin
      got = (rad_seen.size() > i) ? rad_seen[i] : -1;
      checks++;
      if (got != 4) begin
        errors++; $display("FAIL b2b_sq_rad%0d: got %0d expected 4", i, got);
      end
    end
  endtask

  task automatic test_busy_model();
    int got;
    int v;
    clear_log();
    busy_mode = 2;
    busy_cnt  = 0;
    for (int i = 0; i < 4 * N; i++) begin
      v = int'($signed(8'($urandom_range(0, 255))));
      if (i < 2 * N) v = v / 4 * 4;
      send(v);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    drain(4);
    busy_mode = 0;
    sq_busy   = 1'b0;
    checks++;
    if (accepted != 4 * N) begin
      errors++; $display("FAIL model_accepted: got %0d expected %0d", accepted, 4 * N);
    end
    checks++;
    if (starts != 4) begin
      errors++; $display("FAIL model_starts: got %0d expected 4", starts);
    end
    checks++;
    if (start_busy_viol != 0) begin
      errors++; $display("FAIL model_start_busy: got %0d expected 0", start_busy_viol);
    end
    checks++;
    if (win_count != 4) begin
      errors++; $display("FAIL model_win_done: got %0d expected 4", win_count);
    end
    foreach (exp_rad[i]) begin
      got = (rad_seen.size() > i) ? rad_seen[i] : -1;
      checks++;
      if (got != exp_rad[i]) begin
        errors++; $display("FAIL model_sq_rad%0d: got %0d expected %0d", i, got, exp_rad[i]);
      end
`ifdef RMS_PEAK_EN
      got = (peak_seen.size() > i) ? peak_seen[i] : -1;
      checks++;
      if (got != exp_peak[i]) begin
        errors++; $display("FAIL model_peak%0d: got %0d expected %0d", i, got, exp_peak[i]);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    int got;
    clear_log();
    for (int i = 0; i < 7; i++) send(10);
    rst_n = 1'b0;
    #1;
    checks++;
    if (sq_start !== 1'b0 || win_done !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ctrl: got start=%b done=%b ready=%b expected 0 0 1",
               sq_start, win_done, s_ready);
    end
    checks++;
    if (sq_rad !== '0) begin
      errors++; $display("FAIL midrst_sq_rad: got %0d expected 0", sq_rad);
    end
    idle(2);
    clear_log();
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < N; i++) send(1);
    drain(1);
    got = (rad_seen.size() > 0) ? rad_seen[0] : -1;
    checks++;
    if (got != 1) begin
      errors++; $display("FAIL midrst_sq_rad_after: got %0d expected 1", got);
    end
    checks++;
    if (starts != 1) begin
      errors++; $display("FAIL midrst_starts: got %0d expected 1", starts);
    end
  endtask

  task automatic test_reset_handoff();
    bit a;
    bit seen;
    clear_log();
    for (int i = 0; i < N; i++) send(5);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (sq_start) begin
        seen = 1'b1;
        break;
      end
      tick(a);
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL hoff_start_seen: got no start expected a start pulse");
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (sq_start !== 1'b0) begin
      errors++; $display("FAIL hoff_start_drop: got %b expected 0", sq_start);
    end
    idle(2);
    clear_log();
    rst_n = 1'b1;
    idle(20);
    checks++;
    if (starts != 0) begin
      errors++; $display("FAIL hoff_no_restart: got %0d starts expected 0", starts);
    end
  endtask

`ifdef RMS_PEAK_EN
  task automatic test_peak();
    int got;
    clear_log();
    send(5); send(-7); send(-128);
    for (int i = 0; i < N - 3; i++) send(0);
    send(5); send(-7);
    for (int i = 0; i < N - 2; i++) send(0);
    drain(2);
    got = (peak_seen.size() > 0) ? peak_seen[0] : -1;
    checks++;
    if (got != 127) begin
      errors++; $display("FAIL peak_w0: got %0d expected 127", got);
    end
    got = (peak_seen.size() > 1) ? peak_seen[1] : -1;
    checks++;
    if (got != 7) begin
      errors++; $display("FAIL peak_w1: got %0d expected 7", got);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_const_windows();
    test_back_to_back();
    test_busy_model();
    test_reset_mid();
    test_reset_handoff();
`ifdef RMS_PEAK_EN
    test_peak();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rms_mean_square.md
Name: rms_mean_square

Overview:
- Upstream front-end for the fixed-point square-root stage in the RMS path.
- Accepts signed samples on a valid/ready stream and squares each one.
- Accumulates the squares over a window of 2^LOG2_N samples and divides by shifting to form the mean square.
- Hands the mean square to the square-root stage through that stage's start/busy protocol, so root = RMS.

Parameters:
- DATA_W, 8: width of the signed two's-complement input sample.
- LOG2_N, 4: log2 of the window length; N = 2^LOG2_N; legal range 1..8.
- OUT_W, 16: width of the radicand driven to the square-root stage; must be >= 2*DATA_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  block can accept a sample this cycle.
- s_data  in  DATA_W  signed sample.
- sq_start  out  1  one-cycle start pulse to the square-root stage.
- sq_rad  out  OUT_W  radicand (mean square) for the square-root stage.
- sq_busy  in  1  square-root stage busy.
- win_done  out  1  one-cycle pulse when a window's mean square is captured.

Behaviour:
- Reset (async assert, sync deassert) clears all state. Output reset values:
  - sq_start=0, sq_rad=0, win_done=0, s_ready=1.
  - Internal: cnt=0, acc=0, pending=0, FSM=IDLE.
- Accept a sample when s_valid && s_ready:
  - sq = s_data*s_data, computed signed and taken as unsigned with 2*DATA_W bits. Max value is (-2^(DATA_W-1))^2, e.g. 16384 for DATA_W=8.
  - acc is 2*DATA_W+LOG2_N bits unsigned; acc += sq.
  - cnt is a LOG2_N-bit counter that increments and wraps.
- Window completion is the accepted sample with cnt==N-1. On the next edge:
  - ms_q <= (acc+sq)>>LOG2_N, saturated to OUT_W (all ones if the value exceeds OUT_W).
  - pending <= 1.
  - acc <= 0, cnt <= 0.
  - win_done pulses for one cycle, registered.
- No sample is ever dropped:
  - s_ready = !(pending && cnt==N-1 && !issue_now).
  - The final sample of a window stalls only while the previous result is still undelivered.
- Handoff FSM:
  - IDLE: if pending && !sq_busy, go to ISSUE.
  - ISSUE (1 cycle): sq_start=1, sq_rad<=ms_q, pending<=0 unless a window completes in the same cycle (then pending stays 1 and ms_q takes the new value). Go to GUARD.
  - GUARD (1 cycle): sq_start=0. sq_busy is ignored because the square-root stage raises busy one cycle after start. Go to WAIT.
  - WAIT: stay until sq_busy==0, then go to IDLE.
  - issue_now is defined as the FSM being in ISSUE this cycle.
- Start discipline: sq_start is never asserted while sq_busy=1 or in GUARD/WAIT, because a re-start would abort the square-root computation in flight.
- sq_rad holds its value from ISSUE until the next ISSUE.
- Latency: the first sq_start occurs 2 cycles after the final sample of a window is accepted when the square-root stage is idle (1 cycle for capture, 1 cycle IDLE->ISSUE).
- Reset mid-window discards the partial accumulation. Reset mid-handoff drops sq_start immediately, with no further pulse.
- s_valid while s_ready=0: s_data must be held stable by the source; the block does not sample it.

Optional Feature:
- Macro RMS_PEAK_EN.
- When defined:
  - Adds output peak [DATA_W-1:0], unsigned, equal to the max |s_data| over the last completed window, captured with ms_q.
  - |-2^(DATA_W-1)| saturates to 2^(DATA_W-1)-1.
  - Reset value is 0.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- DATA_W=8, LOG2_N=4, sq_busy tied 0, 16 samples of +3 -> win_done once; sq_start one cycle 2 clocks after the last sample; sq_rad=9.
- 16 samples of -128 -> sq_rad=16384. Alternating +4/-4 ×16 -> sq_rad=16.
- sq_busy held 1 for 60 cycles, 32 back-to-back samples of +2 (windows 1 and 2) -> no sq_start while busy; s_ready=0 on sample 32 until the first ISSUE. After busy falls, sq_rad=4, pending window is delivered later with sq_rad=4; no sample lost.
- Model square-root stage with busy rising 1 cycle after start and lasting 5 cycles -> exactly one sq_start per window; sq_start never coincides with busy=1.
- Assert rst_n=0 after 7 samples of +10, release, then 16 samples of +1 -> sq_rad=1; all outputs at reset values during reset.
- With RMS_PEAK_EN, window {+5, -7, -128, 0×13} -> peak=127; window {+5, -7, 0×14} -> peak=7.
